// File: rtl/collision_judge.sv
// rtl/collision_judge.sv - bullet/player vs enemy collision judge with explosion, score and lives
module collision_judge #(
  parameter int ENEMY_W        = 50,
  parameter int PLAYER_W       = 50,
  parameter int BULLET_W       = 4,
  parameter int BULLET_H       = 10,
  parameter int EXPLODE_FRAMES = 4,
  parameter int FRAME_TICKS    = 8,
  parameter int LIVES_INIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  enemy_x,
  input  logic [9:0]  enemy_y,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  bullet_x,
  input  logic [9:0]  bullet_y,
  input  logic        bullet_valid,
  output logic        boom,
  output logic        bullet_hit,
  output logic        player_hit,
  output logic        explode_active,
  output logic [1:0]  explode_frame,
  output logic [9:0]  explode_x,
  output logic [9:0]  explode_y,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        game_over
);

  localparam int CW = ($clog2(FRAME_TICKS) < 1) ? 1 : $clog2(FRAME_TICKS);
  localparam logic [10:0] EW = 11'(ENEMY_W);
  localparam logic [10:0] PW = 11'(PLAYER_W);
  localparam logic [10:0] BW = 11'(BULLET_W);
  localparam logic [10:0] BH = 11'(BULLET_H);
  localparam logic [CW-1:0] TICK_LAST = CW'(FRAME_TICKS - 1);
  localparam logic [1:0] FRAME_LAST = 2'(EXPLODE_FRAMES - 1);
  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);

  typedef enum logic [1:0] {IDLE, EXPLODE, OVER} state_t;

  state_t        state;
  logic          tick_q;
  logic [CW-1:0] tick_cnt;
  logic          tick_rise;
  logic          hit_b;
  logic          hit_p;

  // Axis-aligned box overlap; coordinates widened to 11 bits so x+w cannot wrap
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [10:0] aw, input logic [10:0] ah,
                                   input logic [9:0] bx, input logic [9:0] by,
                                   input logic [10:0] bw, input logic [10:0] bh);
    logic [10:0] ax_w, ay_w, bx_w, by_w;
    ax_w = {1'b0, ax};
    ay_w = {1'b0, ay};
    bx_w = {1'b0, bx};
    by_w = {1'b0, by};
    overlap = (ax_w < bx_w + bw) && (bx_w < ax_w + aw) &&
              (ay_w < by_w + bh) && (by_w < ay_w + ah);
  endfunction

  assign tick_rise = frame_tick & ~tick_q;
  assign hit_b = bullet_valid &
                 overlap(bullet_x, bullet_y, BW, BH, enemy_x, enemy_y, EW, EW);
  assign hit_p = overlap(player_x, player_y, PW, PW, enemy_x, enemy_y, EW, EW);

  // Single FSM: collision judging in IDLE, animation pacing in EXPLODE, frozen in OVER
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      tick_q         <= 1'b0;
      tick_cnt       <= '0;
      boom           <= 1'b0;
      bullet_hit     <= 1'b0;
      player_hit     <= 1'b0;
      explode_active <= 1'b0;
      explode_frame  <= 2'd0;
      explode_x      <= 10'd0;
      explode_y      <= 10'd0;
      score          <= 16'd0;
      lives          <= LIVES_RST;
      game_over      <= 1'b0;
    end else begin
      tick_q     <= frame_tick;
      boom       <= 1'b0;
      bullet_hit <= 1'b0;
      player_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_rise && (hit_b || hit_p)) begin
            boom          <= 1'b1;
            explode_x     <= enemy_x;
            explode_y     <= enemy_y;
            explode_frame <= 2'd0;
            tick_cnt      <= '0;
            if (hit_b) begin
              // A bullet kill takes priority over simultaneous player contact
              bullet_hit     <= 1'b1;
              score          <= (score == 16'hFFFF) ? score : score + 16'd1;
              explode_active <= 1'b1;
              state          <= EXPLODE;
            end else begin
              player_hit <= 1'b1;
              lives      <= lives - 3'd1;
              if (lives == 3'd1) begin
                game_over      <= 1'b1;
                explode_active <= 1'b0;
                state          <= OVER;
              end else begin
                explode_active <= 1'b1;
                state          <= EXPLODE;
              end
            end
          end
        end
        EXPLODE: begin
          if (tick_rise) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (explode_frame == FRAME_LAST) begin
                explode_frame  <= 2'd0;
                explode_active <= 1'b0;
                state          <= IDLE;
              end else begin
                explode_frame <= explode_frame + 2'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        default: begin
          game_over <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_judge.sv
// tb/tb_collision_judge.sv - directed self-checking bench for collision_judge
module tb_collision_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [9:0]  enemy_x, enemy_y, player_x, player_y, bullet_x, bullet_y;
  logic        bullet_valid;
  logic        boom, bullet_hit, player_hit, explode_active, game_over;
  logic [1:0]  explode_frame;
  logic [9:0]  explode_x, explode_y;
  logic [15:0] score;
  logic [2:0]  lives;

  int passed = 0;
  int total  = 0;
  logic boom_seen;

  collision_judge dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
    .player_x(player_x), .player_y(player_y),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_valid(bullet_valid),
    .boom(boom), .bullet_hit(bullet_hit), .player_hit(player_hit),
    .explode_active(explode_active), .explode_frame(explode_frame),
    .explode_x(explode_x), .explode_y(explode_y),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One frame_tick pulse; returns on the falling edge after the capturing rising edge
  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      boom_seen = boom_seen | boom | bullet_hit | player_hit;
    end
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; bullet_valid = 1'b0;
    enemy_x = 10'd100; enemy_y = 10'd200;
    player_x = 10'd600; player_y = 10'd600;
    bullet_x = 10'd150; bullet_y = 10'd240;
    repeat (3) @(negedge clk);
    check("rst_boom", 16'(boom), 16'd0);
    check("rst_score", score, 16'd0);
    check("rst_lives", 16'(lives), 16'd3);
    check("rst_over", 16'(game_over), 16'd0);
    check("rst_active", 16'(explode_active), 16'd0);
    rst = 1'b1;

    // Bullet just past enemy right edge: no overlap
    bullet_valid = 1'b1;
    tick();
    check("edge_boom", 16'(boom), 16'd0);
    check("edge_score", score, 16'd0);

    // Bullet inside enemy box
    bullet_x = 10'd120;
    tick();
    check("hit_boom", 16'(boom), 16'd1);
    check("hit_bullet", 16'(bullet_hit), 16'd1);
    check("hit_player", 16'(player_hit), 16'd0);
    check("hit_score", score, 16'd1);
    check("hit_ex", 16'(explode_x), 16'd100);
    check("hit_ey", 16'(explode_y), 16'd200);
    check("hit_active", 16'(explode_active), 16'd1);
    check("hit_frame", 16'(explode_frame), 16'd0);
    @(negedge clk);
    check("hit_boom_1cyc", 16'(boom), 16'd0);

    // Explosion pacing with a live overlapping bullet that must be ignored
    boom_seen = 1'b0;
    ticks(8);
    check("exp_frame8", 16'(explode_frame), 16'd1);
    ticks(23);
    check("exp_frame31", 16'(explode_frame), 16'd3);
    check("exp_active31", 16'(explode_active), 16'd1);
    check("exp_ignored", 16'(boom_seen), 16'd0);
    check("exp_score", score, 16'd1);
    ticks(1);
    check("exp_done_active", 16'(explode_active), 16'd0);
    check("exp_done_frame", 16'(explode_frame), 16'd0);

    // Simultaneous bullet and player hit: bullet wins
    player_x = 10'd110; player_y = 10'd210;
    tick();
    check("both_bullet", 16'(bullet_hit), 16'd1);
    check("both_player", 16'(player_hit), 16'd0);
    check("both_lives", 16'(lives), 16'd3);
    check("both_score", score, 16'd2);
    ticks(32);

    // Three player hits, each followed by a full explosion
    bullet_valid = 1'b0;
    tick();
    check("p1_hit", 16'(player_hit), 16'd1);
    check("p1_boom", 16'(boom), 16'd1);
    check("p1_lives", 16'(lives), 16'd2);
    check("p1_active", 16'(explode_active), 16'd1);
    ticks(32);
    check("p1_lives_hold", 16'(lives), 16'd2);
    tick();
    check("p2_lives", 16'(lives), 16'd1);
    check("p2_over", 16'(game_over), 16'd0);
    ticks(32);
    tick();
    check("p3_hit", 16'(player_hit), 16'd1);
    check("p3_lives", 16'(lives), 16'd0);
    check("p3_over", 16'(game_over), 16'd1);
    enemy_x = 10'd300; enemy_y = 10'd300;
    bullet_valid = 1'b1; bullet_x = 10'd310; bullet_y = 10'd310;
    boom_seen = 1'b0;
    ticks(2);
    check("over_noboom", 16'(boom_seen), 16'd0);
    check("over_score", score, 16'd2);
    check("over_ex", 16'(explode_x), 16'd100);
    check("over_hold", 16'(game_over), 16'd1);

    // Reset out of OVER
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_over_go", 16'(game_over), 16'd0);
    check("rst_over_lives", 16'(lives), 16'd3);
    rst = 1'b1;

    // Score saturation from a preloaded maximum
    player_x = 10'd900; player_y = 10'd900;
    force dut.score = 16'hFFFF;
    @(negedge clk);
    release dut.score;
    @(negedge clk);
    check("sat_preload", score, 16'hFFFF);
    tick();
    check("sat_boom", 16'(boom), 16'd1);
    check("sat_score", score, 16'hFFFF);

    // frame_tick held high counts once
    @(negedge clk); frame_tick = 1'b1;
    repeat (10) @(negedge clk);
    frame_tick = 1'b0;
    check("held_frame", 16'(explode_frame), 16'd0);
    ticks(7);
    check("held_frame8", 16'(explode_frame), 16'd1);

    // Reset mid-explosion
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("mid_rst_active", 16'(explode_active), 16'd0);
    check("mid_rst_frame", 16'(explode_frame), 16'd0);
    check("mid_rst_score", score, 16'd0);
    check("mid_rst_ex", 16'(explode_x), 16'd0);
    check("mid_rst_boom", 16'(boom | bullet_hit | player_hit), 16'd0);
    bullet_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    boom_seen = 1'b0;
    ticks(2);
    check("post_rst_nopulse", 16'(boom_seen), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
